// File: rtl/toggle_event_sink_pkg.sv
// Shared constants for the toggle-event crossing; also used by the upstream toggle source.
package toggle_event_sink_pkg;

  localparam int TOG_CNT_W_DEFAULT = 4;

  // Saturation point of a w-bit pending-event counter.
  function automatic int unsigned max_cnt(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/toggle_event_sink_edge_detect.sv
// Turns a synchronized toggle level into a registered one-cycle event pulse (1 cycle latency).
// Reset loads the current level so releasing reset never produces an event.
module toggle_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic tog_i,
  output logic evt_o
);

  logic prev_q;
  logic evt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= tog_i;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= tog_i;
      evt_q  <= tog_i ^ prev_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/toggle_event_sink.sv
// Toggle-to-event sink: counts synchronized toggle events (visible 2 cycles after sampling),
// presents them over valid/ready and returns one ack toggle per consumed event; saturates with sticky overflow.
module toggle_event_sink
  import toggle_event_sink_pkg::*;
#(
  parameter int CNT_W  = TOG_CNT_W_DEFAULT,
  parameter bit ACK_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_tog,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [CNT_W-1:0] io_pending,
  output logic             io_overflow,
  input  logic             io_clr_overflow,
  output logic             io_ack_tog
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cnt(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             evt;
  logic             fire;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;

  toggle_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .tog_i (io_tog),
    .evt_o (evt)
  );

  assign io_out_valid = (cnt_q != '0);
  assign fire         = io_out_valid & io_out_ready;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = io_clr_overflow ? 1'b0 : ovf_q;
    ack_d = ACK_EN ? (ack_q ^ fire) : 1'b0;
    if (evt && !fire) begin
      // Set beats a simultaneous clear: the saturating event must not be lost.
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (!evt && fire) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      ack_q <= ack_d;
    end
  end

  assign io_pending  = cnt_q;
  assign io_overflow = ovf_q;
  assign io_ack_tog  = ack_q;

endmodule

// File: tb/tb_toggle_event_sink.sv
// Directed bench for toggle_event_sink with a cycle-level event-accounting model and literal spot checks.
module tb_toggle_event_sink;

  localparam int MAXC = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_tog = 1'b1;
  logic       io_out_ready = 1'b0;
  logic       io_clr_overflow = 1'b0;
  logic       io_out_valid, io_overflow, io_ack_tog;
  logic [3:0] io_pending;
  logic       v0, o0, a0;
  logic [3:0] p0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  toggle_event_sink #(.CNT_W(4), .ACK_EN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .io_tog(io_tog),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_pending(io_pending), .io_overflow(io_overflow),
    .io_clr_overflow(io_clr_overflow), .io_ack_tog(io_ack_tog)
  );

  toggle_event_sink #(.CNT_W(4), .ACK_EN(1'b0)) u_dut_noack (
    .clock(clock), .reset(reset), .io_tog(io_tog),
    .io_out_valid(v0), .io_out_ready(io_out_ready),
    .io_pending(p0), .io_overflow(o0),
    .io_clr_overflow(io_clr_overflow), .io_ack_tog(a0)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an event is "seen" when the sampled level differs from the last sampled level,
  // and lands in the occupancy one edge later. Occupancy moves by (arrivals - consumptions).
  int m_cnt = 0;
  bit m_ovf = 0, m_ack = 0, m_last = 0, m_arrive = 0, m_init = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; m_ovf = 0; m_ack = 0; m_arrive = 0;
      m_last = io_tog;
      m_init = 1;
    end else begin
      int consumed;
      int net;
      consumed = (m_cnt > 0 && io_out_ready) ? 1 : 0;
      net = int'(m_arrive) - consumed;
      if (net > 0 && m_cnt == MAXC) m_ovf = 1;
      else begin
        if (io_clr_overflow) m_ovf = 0;
        m_cnt = m_cnt + net;
      end
      if (consumed == 1) m_ack = ~m_ack;
      m_arrive = (io_tog != m_last);
      m_last = io_tog;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      check("mdl_pending", int'(io_pending), m_cnt);
      check("mdl_valid", int'(io_out_valid), int'(m_cnt != 0));
      check("mdl_overflow", int'(io_overflow), int'(m_ovf));
      check("mdl_ack", int'(io_ack_tog), int'(m_ack));
      check("noack_ack", int'(a0), 0);
      check("noack_pending", int'(p0), m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // Reset release with io_tog held high.
    cyc(3);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      check("rst_rel_pending", int'(io_pending), 0);
      check("rst_rel_valid", int'(io_out_valid), 0);
    end

    // Toggles at 0,4,8 with ready low.
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      check("accum_pending", int'(io_pending), int'(c >= 2) + int'(c >= 6) + int'(c >= 10));
      check("accum_ack", int'(io_ack_tog), 0);
      if (c % 4 == 0 && c <= 8) io_tog = ~io_tog;
    end

    // Drain three with ready held; extra ready cycles must not underflow.
    cyc(1);
    io_out_ready = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      cyc(1);
      check("drain_pending", int'(io_pending), (d <= 3) ? 3 - d : 0);
      check("drain_ack", int'(io_ack_tog), (d >= 3) ? 1 : d % 2);
      check("drain_valid", int'(io_out_valid), int'(d < 3));
    end
    io_out_ready = 1'b0;

    // 16 toggles every 2 cycles: saturate at 15, overflow on the 16th.
    for (int c = 0; c < 34; c++) begin
      cyc(1);
      if (c == 30) begin
        check("sat_pending_15", int'(io_pending), 15);
        check("sat_ovf_before", int'(io_overflow), 0);
      end
      if (c == 32) begin
        check("sat_pending_hold", int'(io_pending), 15);
        check("sat_ovf_set", int'(io_overflow), 1);
      end
      if (c % 2 == 0 && c <= 30) io_tog = ~io_tog;
    end

    io_clr_overflow = 1'b1;
    cyc(1);
    io_clr_overflow = 1'b0;
    check("ovf_cleared", int'(io_overflow), 0);

    // Clear coincident with a saturating arrival: overflow stays set.
    io_tog = ~io_tog;
    cyc(1);
    io_clr_overflow = 1'b1;
    cyc(1);
    io_clr_overflow = 1'b0;
    check("ovf_set_wins", int'(io_overflow), 1);
    check("ovf_set_pending", int'(io_pending), 15);

    io_clr_overflow = 1'b1;
    cyc(1);
    io_clr_overflow = 1'b0;

    // Arrival and consumption in the same cycle while full.
    io_tog = ~io_tog;
    cyc(1);
    io_out_ready = 1'b1;
    cyc(1);
    io_out_ready = 1'b0;
    check("evt_fire_pending", int'(io_pending), 15);
    check("evt_fire_ovf", int'(io_overflow), 0);
    check("evt_fire_ack", int'(io_ack_tog), 0);

    // Drain 11 to reach 4 with ack=1, then add one event -> 5.
    io_out_ready = 1'b1;
    cyc(11);
    io_out_ready = 1'b0;
    io_tog = ~io_tog;
    cyc(2);
    check("pre_rst_pending", int'(io_pending), 5);
    check("pre_rst_ack", int'(io_ack_tog), 1);

    // Reset with a toggle in flight.
    io_tog = ~io_tog;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("rst_pending", int'(io_pending), 0);
    check("rst_valid", int'(io_out_valid), 0);
    check("rst_ack", int'(io_ack_tog), 0);
    check("rst_ovf", int'(io_overflow), 0);
    reset = 1'b0;
    cyc(4);
    check("post_rst_pending", int'(io_pending), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_event_sink.md
Name: toggle_event_sink

Overview:
- Consumer stage placed directly downstream of a 3-deep async-reset synchronizer shift register (1-bit, init 0).
- Converts the synchronized toggle level into discrete events, buffers them in a saturating pending counter and presents them to local logic over a valid/ready interface.
- Returns a toggle acknowledge upstream for each consumed event; that acknowledge travels through its own reverse synchronizer.
- Single clock domain (the destination domain of the crossing).

Parameters:
- CNT_W, 4, width of pending-event counter; max buffered events = 2^CNT_W-1.
- ACK_EN, 1, 1 = generate io_ack_tog; 0 = io_ack_tog held 0.

Ports:
- clock  input  1  destination-domain clock.
- reset  input  1  synchronous, active-high reset.
- io_tog  input  1  synchronized toggle from synchronizer io_q; each level change = one event.
- io_out_valid  output  1  at least one event pending.
- io_out_ready  input  1  consumer accepts one event when valid&ready.
- io_pending  output  CNT_W  current pending-event count.
- io_overflow  output  1  sticky: an event arrived while counter saturated.
- io_clr_overflow  input  1  clears io_overflow.
- io_ack_tog  output  1  toggles once per consumed event (upstream credit return).

Behaviour:
- One clock, synchronous active-high reset. All state updates on the rising edge of clock.
- Reset values: io_out_valid=0, io_pending=0, io_overflow=0, io_ack_tog=0.
- During reset, prev_tog loads io_tog. No spurious event on reset release, whatever io_tog's level is.
- Edge detect: evt_r <= io_tog ^ prev_tog and prev_tog <= io_tog, every cycle. evt_r is a registered one-cycle pulse.
- Latency: io_tog change sampled at edge N -> evt_r high at N+1 -> count incremented at N+2. io_out_valid/io_pending reflect it from N+2 (2 cycles).
- fire = io_out_valid & io_out_ready.
- Counter update per cycle:
  - evt_r & !fire: count+1, unless count==2^CNT_W-1; then count unchanged and io_overflow<=1.
  - !evt_r & fire: count-1.
  - evt_r & fire: count unchanged. No overflow even when saturated, because net occupancy does not grow.
  - neither: hold.
- io_out_valid = (count != 0). It is combinational from the count register only and never depends on io_out_ready.
- io_out_ready while io_out_valid=0 has no effect. The count never underflows.
- io_overflow is sticky. io_clr_overflow=1 clears it next edge. If a saturating event and clear occur in the same cycle, set wins (io_overflow=1).
- io_ack_tog inverts on every fire when ACK_EN=1; it is a registered output. ACK_EN=0: constant 0.
- Reset asserted mid-operation clears pending events and overflow. In-flight evt_r is discarded. io_ack_tog returns to 0, so the upstream sender must be reset in the same window.
- io_tog is not re-synchronized here. This block must only be fed from a synchronizer output.

Decomposition:
- Shared package: TOG_CNT_W_DEFAULT=4 and the saturation constant function max_cnt(w)=2^w-1, both reused by the upstream toggle source.
- One sub-module: toggle_edge_detect (prev_tog and evt_r registers, reset-load of prev_tog). The counter, overflow and ack logic stay in the top module.

Test Plan:
- Reset release with io_tog=1 held -> evt_r never pulses; io_pending=0 and io_out_valid=0 for 10 cycles.
- io_tog toggles at cycles 0,4,8, io_out_ready=0 -> io_pending goes 1@2, 2@6, 3@10; io_out_valid=1 from cycle 2; io_ack_tog=0.
- Pending=3, io_out_ready=1 continuously, no new toggles -> three fires; io_pending 2,1,0 on consecutive cycles; io_ack_tog toggles 3 times (ends 1); io_out_valid drops after the third fire.
- CNT_W=4, 16 toggles every 2 cycles with ready=0 -> io_pending saturates at 15; io_overflow=1 after the 16th event; io_clr_overflow pulse -> 0; clear coincident with a new saturating event -> stays 1.
- Pending=15, event and fire in the same cycle -> io_pending stays 15; io_overflow stays 0.
- Reset asserted with pending=5, io_ack_tog=1 -> next edge: pending=0, valid=0, ack=0, overflow=0; a toggle in flight at reset is not counted.
